// File: rtl/spi_reg_slave.sv
// SPI mode-3 register-access slave: 24-bit frames (R/nW, byte count, 13-bit address, data)
// oversampled in the clk domain and turned into single-cycle register read/write strobes.
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic [12:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_WDATA,
    S_RDATA,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic                   r_cs_d;
  logic                   r_sck_d;
  logic                   r_armed;

  state_t      r_state;
  state_t      w_state_nx;
  logic [4:0]  r_bit_cnt;
  logic [14:0] r_shift;
  logic [7:0]  r_tx;
  logic [1:0]  r_rd_pipe;
  logic        r_bad;

  logic        w_cs_n;
  logic        w_sck;
  logic        w_sdi;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_cs_fall;
  logic        w_cs_rise;
  logic [15:0] w_hdr;
  logic        w_hdr_done;
  logic        w_bits_done;
  logic        w_abort;
  logic        w_shifting;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync  <= '1;
      r_sck_sync <= '1;
      r_sdi_sync <= '0;
      r_flush    <= '0;
      r_cs_d     <= 1'b1;
      r_sck_d    <= 1'b1;
      r_armed    <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_cs_d     <= w_cs_n;
      r_sck_d    <= w_sck;
      // Only arm once a genuine idle-high cs_n has propagated out of the synchronizer,
      // so a frame already running when reset drops is never picked up mid-way.
      if (r_flush[SYNC_STAGES-1] && w_cs_n) r_armed <= 1'b1;
    end
  end

  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = r_armed & r_cs_d & ~w_cs_n;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;
  assign w_hdr      = {r_shift, w_sdi};
  assign w_shifting = (r_state == S_INSTR) || (r_state == S_WDATA) || (r_state == S_RDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nx  = r_state;
    w_hdr_done  = 1'b0;
    w_bits_done = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_cs_fall) w_state_nx = S_INSTR;
      S_INSTR: begin
        if (w_cs_rise) begin
          w_abort    = 1'b1;
          w_state_nx = S_IDLE;
        end else if (w_sck_rise && r_bit_cnt == 5'd15) begin
          w_hdr_done = 1'b1;
          w_state_nx = w_hdr[15] ? S_RDATA : S_WDATA;
        end
      end
      S_WDATA, S_RDATA: begin
        if (w_cs_rise) begin
          w_abort    = 1'b1;
          w_state_nx = S_IDLE;
        end else if (w_sck_rise && r_bit_cnt == 5'd23) begin
          w_bits_done = 1'b1;
          w_state_nx  = S_DONE;
        end
      end
      S_DONE: if (w_cs_rise) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_rd_pipe <= '0;
      r_bad     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      sdo       <= 1'b1;
      sdo_oe    <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      r_rd_pipe <= {r_rd_pipe[0], reg_rd_en};
      if (r_rd_pipe[1]) r_tx <= reg_rdata;

      if (r_state == S_IDLE && w_cs_fall) begin
        r_bit_cnt <= '0;
        r_bad     <= 1'b0;
      end else if (w_shifting && w_sck_rise) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        r_shift   <= w_hdr[14:0];
      end

      if (w_hdr_done) begin
        reg_addr <= w_hdr[12:0];
        if (w_hdr[14:13] != 2'b00) begin
          frame_err <= 1'b1;
          r_bad     <= 1'b1;
        end else if (w_hdr[15]) begin
          reg_rd_en <= 1'b1;
        end
      end

      if (w_bits_done && r_state == S_WDATA && !r_bad) begin
        reg_wr_en <= 1'b1;
        reg_wdata <= {r_shift[6:0], w_sdi};
      end

      // A malformed read still owns the line but returns all ones.
      if (r_state == S_RDATA && w_sck_fall) begin
        sdo_oe <= 1'b1;
        sdo    <= r_bad ? 1'b1 : r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end

      if (w_abort) frame_err <= 1'b1;

      if (w_state_nx == S_IDLE) begin
        sdo_oe <= 1'b0;
        sdo    <= 1'b1;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on cs_n, sck and sdi (legal range 2..3).
REQ-002 SHALL have port clk, input, 1: sole system clock; all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port cs_n, input, 1: SPI chip select from master, active low, asynchronous to clk.
REQ-005 SHALL have port sck, input, 1: SPI clock, mode 3 (idles high), asynchronous to clk.
REQ-006 SHALL have port sdi, input, 1: serial data from master, MSB first.
REQ-007 SHALL have port sdo, output, 1: serial read data to master; top level ties to SDIO through sdo_oe.
REQ-008 SHALL have port sdo_oe, output, 1: tristate enable for sdo, high only during the read-data phase.
REQ-009 SHALL have port reg_addr, output, 13: register address of current/last frame.
REQ-010 SHALL have port reg_wdata, output, 8: write data.
REQ-011 SHALL have port reg_wr_en, output, 1: one-clk write strobe.
REQ-012 SHALL have port reg_rd_en, output, 1: one-clk read request strobe.
REQ-013 SHALL have port reg_rdata, input, 8: read data, valid 2 clk after reg_rd_en.
REQ-014 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-015 SHALL have port frame_err, output, 1: one-clk pulse on a malformed or aborted frame.

Function
REQ-016 SHALL pass cs_n, sck and sdi through SYNC_STAGES flops, then edge-detect sck in the clk domain; cs_n and sck sync flops reset to 1.
REQ-017 SHALL be correct for sck half-period >= 4 clk (master runs at clk/16, 8 clk per half-period).
REQ-018 SHALL frame 24 bits: [23] R/nW (1=read), [22:21] W byte-count, [20:8] address, [7:0] data.
REQ-019 SHALL sample sdi on each synced sck rising edge while synced cs_n is low, and drive sdo on synced sck falling edges.
REQ-020 SHALL run FSM IDLE -> INSTR (cs_n fall) -> WDATA or RDATA (after 16th rising edge, per bit 23) -> DONE (after 24th rising edge) -> IDLE (cs_n rise).
REQ-021 SHALL use a 5-bit rising-edge counter cleared on cs_n fall; edges after the 24th SHALL be ignored, with the count held at 24.
REQ-022 SHALL latch reg_addr on the 16th rising edge.
REQ-023 On a read frame, SHALL pulse reg_rd_en exactly once, 1 clk after the 16th rising edge is detected.
REQ-024 On a read frame, SHALL load reg_rdata into the tx shifter 2 clk after reg_rd_en.
REQ-025 On a read frame, SHALL drive rdata[7] on sdo at the next sck falling edge, then shift left one bit per falling edge, 8 bits total.
REQ-026 SHALL raise sdo_oe at that first data falling edge and hold it until the synced cs_n rises.
REQ-027 On a write frame, SHALL pulse reg_wr_en exactly once, 1 clk after the 24th rising edge, with reg_wdata = bits [7:0].
REQ-028 If W != 00, SHALL pulse frame_err at the 16th rising edge, suppress reg_rd_en/reg_wr_en, and drive sdo=1 for the rest of the frame.
REQ-029 If cs_n rises before the 24th rising edge, SHALL go to IDLE within 1 clk of the synced rise, pulse frame_err, issue no reg_wr_en, and drop sdo_oe.
REQ-030 A read aborted after reg_rd_en SHALL NOT retract the strobe.
REQ-031 SHALL hold busy high from synced cs_n fall through synced cs_n rise.
REQ-032 SHALL accept back-to-back frames with cs_n high for >= SYNC_STAGES+1 clk.
REQ-033 SHALL leave sdo at 1 whenever sdo_oe is low.

Reset
REQ-034 While rst is high, SHALL force: FSM=IDLE, counter=0, sdo=1, sdo_oe=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wdata=0, busy=0, frame_err=0.
REQ-035 On reset asserted mid-frame, SHALL discard the frame with no strobes.
REQ-036 After rst release, SHALL wait for a fresh cs_n fall; a frame already in progress SHALL be ignored until cs_n rises.

Verification
REQ-037 Write: master sends 0x000503 at clk/16 -> exactly one reg_wr_en with reg_addr=0x005 and reg_wdata=0x03; sdo_oe stays 0.
REQ-038 Read: master sends 0x801400 with reg_rdata=0x20 -> one reg_rd_en with reg_addr=0x014; master samples 0x20 on rising edges 17..24; sdo_oe high only in the data phase.
REQ-039 Abort: cs_n rises after 10 bits of 0x001420 -> frame_err pulse, no strobes, busy low, next frame 0x00FF01 writes addr 0x0FF data 0x01.
REQ-040 Bad W: frame 0x200503 -> frame_err pulse at bit 16, no reg_wr_en.
REQ-041 Back-to-back: frames 0x000503, 0x001420, 0x00FF01 with 3 clk cs_n gap -> three reg_wr_en pulses in order, correct addr/data.
REQ-042 Reset: rst asserted at bit 20 of a write, released, frame repeated -> no strobe for the first frame, one correct strobe for the repeat.
